ps2_keyboard: RTL and testbench
===============================

# ps2_keyboard

Receives PS/2 keyboard frames from the board connector and decodes them into the key command consumed by `Pacman_Control`. It synchronizes and glitch-filters the PS/2 clock and data lines, deframes 11-bit frames, and tracks make/break/extended prefixes. Direction keys are translated into the one-byte direction codes the pacman controller expects:

- up = 8'h48
- left = 8'h4B
- down = 8'h50
- right = 8'h4D

It also provides a held-key level.

## Interface

Parameters:
- `FILTER_LEN`, 4: consecutive equal `clk` samples needed to accept a new `ps2_clk` level.
- `TIMEOUT`, 20000: `clk` cycles without a falling `ps2_clk` edge before a partial frame is discarded.

Ports (one clock domain, `clk`; reset is synchronous and active-high on `rst`):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `ps2_byte`  out  8  last accepted direction code (48/4B/50/4D), registered.
- `ps2_state`  out  1  1 while the key in `ps2_byte` is held, registered.
- `frame_err`  out  1  one-cycle pulse on a parity or stop-bit error.

## Operation

Input conditioning:
- Each raw input passes through a 2-flop synchronizer.
- Filtered clock level changes only after `FILTER_LEN` consecutive identical synchronized samples.
- Data is sampled from the synchronizer output on the filtered falling edge.

Frame FSM (states IDLE, DATA, PARITY, STOP; one transition per filtered falling edge):
- IDLE: data=0 → DATA, with bit counter cleared. data=1 → stay in IDLE; this is not an error.
- DATA: shift in 8 bits LSB first; after the 8th bit → PARITY.
- PARITY: store the bit → STOP.
- STOP: the frame is good when data=1 and the XOR of 8 data bits and parity is 1 (odd parity). A good frame produces a one-cycle internal `byte_valid`. Otherwise `frame_err` pulses. Either way the FSM returns to IDLE.
- Timeout: in any state other than IDLE, a cycle counter reaching `TIMEOUT` with no falling edge forces IDLE. The frame is dropped silently; no `frame_err`.

Decoder (acts on `byte_valid`):
- 8'hE0 sets `ext`.
- 8'hF0 sets `brk`.
- Any other byte is a key code; `ext` and `brk` both clear after it.

Key code mapping:
- up: `ext` with 75, or non-`ext` 1D (W) → 48.
- left: `ext` with 6B, or non-`ext` 1C (A) → 4B.
- down: `ext` with 72, or non-`ext` 1B (S) → 50.
- right: `ext` with 74, or non-`ext` 23 (D) → 4D.
- All other codes are ignored; outputs are unchanged.

Make and break handling:
- Make of a mapped key: `ps2_byte` ← mapped code, `ps2_state` ← 1. Typematic repeats rewrite the same values.
- Break of a mapped key: if its mapped code equals `ps2_byte`, `ps2_state` ← 0. Otherwise no change (an older key was released). `ps2_byte` is never cleared by a break.
- Reset: `ps2_byte`=8'h00, `ps2_state`=0, `frame_err`=0. FSM goes to IDLE; `ext`, `brk`, filter and timeout counters clear.
- Reset mid-frame: the partial frame is discarded; the next start bit begins a fresh frame.

## Timing

- Filtered falling edge is detected 2 + `FILTER_LEN` `clk` cycles after the raw `ps2_clk` fall, assuming it stays stable.
- `byte_valid` / `frame_err` are asserted in the cycle after the stop-bit edge is detected.
- `ps2_byte` / `ps2_state` update in the cycle after `byte_valid`, i.e. 2 cycles after the stop-bit edge.
- Outputs are held stable between updates; `ps2_state` is level, not pulse.
- `rst` has priority over every other event in the same cycle.
- Minimum supported `clk` is 100× the PS/2 clock (10–16.7 kHz). The timeout counter is wide enough for `TIMEOUT`.

## Test plan

- Frames E0, 75 with valid parity → `ps2_byte`=8'h48, `ps2_state`=1 two cycles after the second stop edge; `frame_err` never pulses.
- Then E0, F0, 75 → `ps2_state`=0, `ps2_byte` stays 8'h48.
- E0 6B (left make), E0 72 (down make), E0 F0 6B (left break) → `ps2_byte`=8'h50, `ps2_state`=1 throughout the final break.
- Byte 1D with wrong parity → single-cycle `frame_err`, outputs unchanged. A following correct 1D → `ps2_byte`=8'h48, `ps2_state`=1.
- Send 5 bits then idle for `TIMEOUT`+10 cycles, then a full 23 (D) frame → `ps2_byte`=8'h4D, `ps2_state`=1, no `frame_err`. Also inject sub-`FILTER_LEN` glitches on `ps2_clk`; they cause no extra bits.
- Assert `rst` mid-frame after a held key → outputs 8'h00/0 next cycle. A subsequent E0 74 → `ps2_byte`=8'h4D, `ps2_state`=1.

Source files
------------

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver. It synchronizes and filters the PS/2 lines, deframes 11-bit frames,
// and turns arrow and WASD make/break codes into the pacman direction byte and a held-key level.
module ps2_keyboard #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_byte,
  output logic       ps2_state,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync_reg;
  logic [1:0]    data_sync_reg;
  logic          filt_clk_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          fall_reg;
  state_t        state_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          parity_reg;
  logic [TW-1:0] tmo_reg;
  logic          byte_valid_reg;
  logic          ext_reg;
  logic          brk_reg;
  logic [7:0]    key_code;

  // Two-flop synchronizers, plus a filter that accepts a new clock level only after it persists.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
      filt_clk_reg  <= 1'b1;
      filt_cnt_reg  <= '0;
      fall_reg      <= 1'b0;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
      fall_reg      <= 1'b0;
      if (clk_sync_reg[1] != filt_clk_reg) begin
        if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
          filt_clk_reg <= clk_sync_reg[1];
          filt_cnt_reg <= '0;
          fall_reg     <= filt_clk_reg;
        end else begin
          filt_cnt_reg <= filt_cnt_reg + FW'(1);
        end
      end else begin
        filt_cnt_reg <= '0;
      end
    end
  end

  // Frame deserializer; one transition per filtered falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      parity_reg     <= 1'b0;
      tmo_reg        <= '0;
      byte_valid_reg <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      byte_valid_reg <= 1'b0;
      frame_err      <= 1'b0;
      if (fall_reg) begin
        tmo_reg <= '0;
        case (state_reg)
          IDLE: begin
            if (!data_sync_reg[1]) begin
              state_reg   <= DATA;
              bit_cnt_reg <= '0;
            end
          end
          DATA: begin
            shift_reg   <= {data_sync_reg[1], shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) state_reg <= PARITY;
          end
          PARITY: begin
            parity_reg <= data_sync_reg[1];
            state_reg  <= STOP;
          end
          default: begin
            if (data_sync_reg[1] && ((^shift_reg) ^ parity_reg)) byte_valid_reg <= 1'b1;
            else frame_err <= 1'b1;
            state_reg <= IDLE;
          end
        endcase
      end else if (state_reg != IDLE) begin
        // A stalled partial frame is dropped without flagging an error.
        if (tmo_reg == TW'(TIMEOUT - 1)) begin
          state_reg <= IDLE;
          tmo_reg   <= '0;
        end else begin
          tmo_reg <= tmo_reg + TW'(1);
        end
      end
    end
  end

  always_comb begin
    key_code = 8'h00;
    if (ext_reg) begin
      case (shift_reg)
        8'h75:   key_code = 8'h48;
        8'h6B:   key_code = 8'h4B;
        8'h72:   key_code = 8'h50;
        8'h74:   key_code = 8'h4D;
        default: key_code = 8'h00;
      endcase
    end else begin
      case (shift_reg)
        8'h1D:   key_code = 8'h48;
        8'h1C:   key_code = 8'h4B;
        8'h1B:   key_code = 8'h50;
        8'h23:   key_code = 8'h4D;
        default: key_code = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_reg   <= 1'b0;
      brk_reg   <= 1'b0;
      ps2_byte  <= 8'h00;
      ps2_state <= 1'b0;
    end else if (byte_valid_reg) begin
      if (shift_reg == 8'hE0) begin
        ext_reg <= 1'b1;
      end else if (shift_reg == 8'hF0) begin
        brk_reg <= 1'b1;
      end else begin
        ext_reg <= 1'b0;
        brk_reg <= 1'b0;
        if (key_code != 8'h00) begin
          if (!brk_reg) begin
            ps2_byte  <= key_code;
            ps2_state <= 1'b1;
          end else if (key_code == ps2_byte) begin
            ps2_state <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Scoreboard bench for ps2_keyboard: a driver serializes PS/2 frames and queues the model's
// expectation; a monitor pops and compares once each frame has completed.
module tb_ps2_keyboard;
  localparam int FL   = 4;
  localparam int TMO  = 2000;
  localparam int HALF = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic [7:0] ps2_byte;
  logic ps2_state;
  logic frame_err;

  ps2_keyboard #(.FILTER_LEN(FL), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_byte(ps2_byte), .ps2_state(ps2_state), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       s;
    int         e;
    string      name;
  } exp_t;

  exp_t q[$];
  event done;
  int checks = 0;
  int passes = 0;
  int err_cycles = 0;
  int err_base = 0;

  logic [7:0] m_byte = 8'h00;
  logic m_state = 1'b0;
  logic m_ext = 1'b0;
  logic m_brk = 1'b0;

  // {extended, scan code, direction}
  int key_tab[8][3] = '{'{1, 'h75, 'h48}, '{0, 'h1D, 'h48}, '{1, 'h6B, 'h4B}, '{0, 'h1C, 'h4B},
                        '{1, 'h72, 'h50}, '{0, 'h1B, 'h50}, '{1, 'h74, 'h4D}, '{0, 'h23, 'h4D}};

  always @(negedge clk) if (frame_err) err_cycles++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [7:0] b, input logic bad, input string name);
    exp_t x;
    int code;
    if (!bad) begin
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        code = 0;
        foreach (key_tab[i]) if (key_tab[i][0] == int'(m_ext) && key_tab[i][1] == int'(b)) code = key_tab[i][2];
        if (code != 0) begin
          if (!m_brk) begin
            m_byte = 8'(code);
            m_state = 1'b1;
          end else if (8'(code) == m_byte) m_state = 1'b0;
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
    x.b = m_byte; x.s = m_state; x.e = bad ? 1 : 0; x.name = name;
    q.push_back(x);
  endtask

  // Each bit: data set while clock high, then a low half-period; optional short clock glitch.
  task automatic send_bits(input logic [10:0] bits, input int n, input logic glitch);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      if (glitch) begin
        cycles(10);
        ps2_clk = 1'b0;
        cycles(FL - 1);
        ps2_clk = 1'b1;
        cycles(HALF - 10 - (FL - 1));
      end else begin
        cycles(HALF);
      end
      ps2_clk = 1'b0;
      cycles(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad, input logic glitch, input string name);
    logic par;
    par = ~(^b) ^ bad;
    model(b, bad, name);
    send_bits({1'b1, par, b, 1'b0}, 11, glitch);
    cycles(5);
    -> done;
    cycles(20);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(done);
      @(negedge clk);
      if (q.size() == 0) begin
        check("queue_underflow", 1, 0);
      end else begin
        x = q.pop_front();
        check({x.name, "_byte"}, int'(ps2_byte), int'(x.b));
        check({x.name, "_state"}, int'(ps2_state), int'(x.s));
        check({x.name, "_err"}, err_cycles - err_base, x.e);
        $display("frame %s: byte=%0h state=%0b err_cycles=%0d", x.name, ps2_byte, ps2_state, err_cycles - err_base);
        err_base = err_cycles;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] pool[12] = '{8'hE0, 8'hF0, 8'h75, 8'h6B, 8'h72, 8'h74, 8'h1D, 8'h1C, 8'h1B, 8'h23, 8'hE0, 8'h00};

  initial begin
    logic [7:0] b;
    cycles(5);
    check("reset_byte", int'(ps2_byte), 0);
    check("reset_state", int'(ps2_state), 0);
    check("reset_err", int'(frame_err), 0);
    rst = 1'b0;
    cycles(10);

    send_frame(8'hE0, 0, 0, "up_pfx");
    send_frame(8'h75, 0, 0, "up_make");
    send_frame(8'hE0, 0, 0, "upbrk_e0");
    send_frame(8'hF0, 0, 0, "upbrk_f0");
    send_frame(8'h75, 0, 0, "up_break");
    send_frame(8'hE0, 0, 0, "l_e0");
    send_frame(8'h6B, 0, 0, "left_make");
    send_frame(8'hE0, 0, 0, "d_e0");
    send_frame(8'h72, 0, 0, "down_make");
    send_frame(8'hE0, 0, 0, "lb_e0");
    send_frame(8'hF0, 0, 0, "lb_f0");
    send_frame(8'h6B, 0, 0, "left_old_break");
    send_frame(8'h1D, 1, 0, "w_bad_parity");
    send_frame(8'h1D, 0, 0, "w_make");

    send_bits({3'b111, 8'h23, 1'b0}, 5, 0);
    cycles(TMO + 10);
    send_frame(8'h23, 0, 1, "d_after_timeout_glitch");

    send_bits({3'b111, 8'h1C, 1'b0}, 5, 0);
    rst = 1'b1;
    cycles(1);
    check("midrst_byte", int'(ps2_byte), 0);
    check("midrst_state", int'(ps2_state), 0);
    rst = 1'b0;
    m_byte = 8'h00; m_state = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
    cycles(10);
    send_frame(8'hE0, 0, 0, "r_e0");
    send_frame(8'h74, 0, 0, "right_make");

    for (int i = 0; i < 18; i++) begin
      b = pool[$urandom_range(0, 11)];
      if (b == 8'h00) b = 8'($urandom);
      send_frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $sformatf("rand%0d_%0h", i, b));
    end

    cycles(50);
    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
